// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Handles byte sizing, fetch flush, access timeout and pipeline stall generation.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_BURST = 4,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic        d_byte_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_valid_o,
  output logic        d_err_o,
  output logic        stall_if_o,
  output logic        stall_mem_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, I_ACC = 2'd1, D_ACC = 2'd2, D_ERR = 2'd3} state_e;

  localparam logic [3:0] BURST_MAX_C = 4'(MAX_D_BURST);
  localparam logic [7:0] TLIMIT_C    = 8'(TIMEOUT - 1);

  function automatic logic [31:0] lb_extend(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return {{24{b[7]}}, b};
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  burst_q, burst_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        flush_pend_q, flush_pend_d;
  logic        d_byte_q, d_byte_d;
  logic [1:0]  d_lane_q, d_lane_d;
  logic        mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic        if_valid_q, if_valid_d, d_valid_q, d_valid_d, d_err_q, d_err_d;

  logic misalign_s, d_win_s, i_win_s, acc_s, end_s, flush_kill_s, unused_s;

  assign misalign_s   = d_req_i & ~d_byte_i & (d_addr_i[1:0] != 2'b00);
  assign d_win_s      = d_req_i & (~if_req_i | (burst_q < BURST_MAX_C));
  assign i_win_s      = if_req_i & ~if_flush_i;
  assign acc_s        = (state_q == I_ACC) | (state_q == D_ACC);
  assign end_s        = acc_s & (mem_ready_i | (tcnt_q == TLIMIT_C));
  assign flush_kill_s = flush_pend_q | if_flush_i;
  assign unused_s     = ^if_addr_i[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: fixed-priority arbitration in IDLE, return on completion/abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (misalign_s)   state_d = D_ERR;
        else if (d_win_s) state_d = D_ACC;
        else if (i_win_s) state_d = I_ACC;
        else              state_d = IDLE;
      end
      I_ACC, D_ACC: begin
        if (end_s) state_d = IDLE;
        else       state_d = state_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: issue on grant, hold, then complete or abort
  always_comb begin
    burst_d      = if_req_i ? burst_q : 4'd0;
    tcnt_d       = tcnt_q;
    flush_pend_d = flush_pend_q;
    d_byte_d     = d_byte_q;
    d_lane_d     = d_lane_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    d_err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (misalign_s) begin
          d_valid_d = 1'b1;
          d_err_d   = 1'b1;
          d_rdata_d = 32'd0;
        end else if (d_win_s) begin
          mem_en_d    = 1'b1;
          mem_we_d    = d_we_i;
          mem_be_d    = d_byte_i ? (4'b0001 << d_addr_i[1:0]) : 4'b1111;
          mem_addr_d  = {d_addr_i[31:2], 2'b00};
          mem_wdata_d = d_byte_i ? {4{d_wdata_i[7:0]}} : d_wdata_i;
          d_byte_d    = d_byte_i;
          d_lane_d    = d_addr_i[1:0];
          tcnt_d      = 8'd0;
          if (if_req_i) burst_d = (burst_q < BURST_MAX_C) ? burst_q + 4'd1 : burst_q;
          else          burst_d = 4'd0;
        end else if (i_win_s) begin
          mem_en_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_be_d     = 4'b1111;
          mem_addr_d   = {if_addr_i[31:2], 2'b00};
          mem_wdata_d  = 32'd0;
          tcnt_d       = 8'd0;
          burst_d      = 4'd0;
          flush_pend_d = 1'b0;
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      I_ACC: begin
        if (end_s) begin
          mem_en_d     = 1'b0;
          mem_we_d     = 1'b0;
          flush_pend_d = 1'b0;
          if (!flush_kill_s) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_ready_i ? mem_rdata_i : 32'd0;
          end else begin
            if_rdata_d = if_rdata_q;
          end
        end else begin
          tcnt_d       = tcnt_q + 8'd1;
          flush_pend_d = flush_kill_s;
        end
      end
      D_ACC: begin
        if (end_s) begin
          mem_en_d  = 1'b0;
          mem_we_d  = 1'b0;
          d_valid_d = 1'b1;
          if (!mem_ready_i) begin
            d_err_d   = 1'b1;
            d_rdata_d = 32'd0;
          end else if (mem_we_q) begin
            d_rdata_d = 32'd0;
          end else if (d_byte_q) begin
            d_rdata_d = lb_extend(mem_rdata_i, d_lane_q);
          end else begin
            d_rdata_d = mem_rdata_i;
          end
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: begin
        tcnt_d = tcnt_q;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q      <= 4'd0;
      tcnt_q       <= 8'd0;
      flush_pend_q <= 1'b0;
      d_byte_q     <= 1'b0;
      d_lane_q     <= 2'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      d_err_q      <= 1'b0;
    end else begin
      burst_q      <= burst_d;
      tcnt_q       <= tcnt_d;
      flush_pend_q <= flush_pend_d;
      d_byte_q     <= d_byte_d;
      d_lane_q     <= d_lane_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      d_err_q      <= d_err_d;
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_valid_o   = d_valid_q;
  assign d_err_o     = d_err_q;
  assign stall_if_o  = if_req_i & ~if_valid_q;
  assign stall_mem_o = d_req_i & ~d_valid_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for data accesses plus
// hand-written sequences for fetch, flush, contention, timeout and reset.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_byte, d_valid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        stall_if, stall_mem, mem_en, mem_we, mem_ready;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.MAX_D_BURST(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_rdata_o(if_rdata), .if_valid_o(if_valid),
    .d_req_i(d_req), .d_we_i(d_we), .d_byte_i(d_byte), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_rdata_o(d_rdata), .d_valid_o(d_valid), .d_err_o(d_err),
    .stall_if_o(stall_if), .stall_mem_o(stall_mem),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        err;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] outs_nonzero();
    return {if_valid, d_valid, d_err, stall_if, stall_mem, mem_en, mem_we, |mem_be,
            |if_rdata, |d_rdata, |mem_addr, |mem_wdata};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int g;
    logic found;
    logic [9:0] got;

    vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h11223344, 32'hDEADBEEF, 0, 1'b0, 4'hF, 32'h100, 32'h11223344, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h103, 32'h0,        32'h80123456, 1, 1'b0, 4'h8, 32'h100, 32'h0,        32'hFFFFFF80};
    vecs[2] = '{1'b1, 1'b1, 32'h101, 32'h5A,       32'h99999999, 0, 1'b0, 4'h2, 32'h100, 32'h5A5A5A5A, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h200, 32'hCAFEF00D, 32'h12345678, 2, 1'b0, 4'hF, 32'h200, 32'hCAFEF00D, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 32'h106, 32'h0,        32'h00AB7F00, 0, 1'b0, 4'h4, 32'h104, 32'h0,        32'hFFFFFFAB};
    vecs[5] = '{1'b0, 1'b1, 32'h109, 32'h100,      32'h12347F56, 0, 1'b0, 4'h2, 32'h108, 32'h0,        32'h0000007F};
    vecs[6] = '{1'b0, 1'b0, 32'h102, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,   32'h0,        32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h301, 32'h77,       32'h0,        0, 1'b1, 4'h0, 32'h0,   32'h0,        32'h0};
    vecs[8] = '{1'b1, 1'b1, 32'h000, 32'hFFFFFFC3, 32'h0,        1, 1'b0, 4'h1, 32'h0,   32'hC3C3C3C3, 32'h0};
    vecs[9] = '{1'b0, 1'b1, 32'h100, 32'h0,        32'h000000FF, 0, 1'b0, 4'h1, 32'h100, 32'h0,        32'hFFFFFFFF};

    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_rdata = 32'h0; mem_ready = 1'b0;

    // Reset and idle
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(outs_nonzero()), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_outs", 32'(outs_nonzero()), 32'h0);

    // Word fetch, ready on the second access cycle
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk("fetch_en", mem_en, 1); chk("fetch_addr", mem_addr, 32'h40);
    chk("fetch_be", mem_be, 4'hF); chk("fetch_we", mem_we, 0); chk("fetch_stall", stall_if, 1);
    @(negedge clk);
    chk("fetch_wait_valid", if_valid, 0);
    mem_ready = 1'b1; mem_rdata = 32'h00A41020;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("fetch_valid", if_valid, 1); chk("fetch_rdata", if_rdata, 32'h00A41020);
    chk("fetch_stall_off", stall_if, 0); chk("fetch_en_off", mem_en, 0);
    if_req = 1'b0;
    @(negedge clk);
    chk("fetch_pulse", if_valid, 0);

    // Flush: blocks grant in IDLE, then kills an in-flight fetch
    if_req = 1'b1; if_addr = 32'h60; if_flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_block", mem_en, 0);
    if_flush = 1'b0;
    @(negedge clk);
    chk("flush_grant", mem_en, 1);
    if_flush = 1'b1;
    @(negedge clk);
    if_flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h11111111;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("flush_en_off", mem_en, 0); chk("flush_no_valid", if_valid, 0);
    chk("flush_rdata_kept", if_rdata, 32'h00A41020);
    @(negedge clk);
    chk("flush_regrant", mem_en, 1); chk("flush_regrant_addr", mem_addr, 32'h60);
    mem_ready = 1'b1; mem_rdata = 32'h22222222;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("flush_next_valid", if_valid, 1); chk("flush_next_rdata", if_rdata, 32'h22222222);
    if_req = 1'b0;
    @(negedge clk);

    // Data access vector table
    for (int i = 0; i < 10; i++) begin
      d_req = 1'b1; d_we = vecs[i].we; d_byte = vecs[i].byt;
      d_addr = vecs[i].addr; d_wdata = vecs[i].wdata; mem_ready = 1'b0;
      @(negedge clk);
      if (vecs[i].err) begin
        chk($sformatf("v%0d_err_en", i), mem_en, 0);
        chk($sformatf("v%0d_err_valid", i), d_valid, 1);
        chk($sformatf("v%0d_err_flag", i), d_err, 1);
        chk($sformatf("v%0d_err_rdata", i), d_rdata, 32'h0);
        d_req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_err_pulse", i), {mem_en, d_valid, d_err}, 3'b000);
      end else begin
        chk($sformatf("v%0d_en", i), mem_en, 1);
        chk($sformatf("v%0d_we", i), mem_we, vecs[i].we);
        chk($sformatf("v%0d_be", i), mem_be, vecs[i].be);
        chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].maddr);
        chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].mwdata);
        chk($sformatf("v%0d_stall", i), stall_mem, 1);
        for (int w = 0; w < vecs[i].waits; w++) begin
          @(negedge clk);
          chk($sformatf("v%0d_hold", i), {mem_en, d_valid}, 2'b10);
        end
        mem_ready = 1'b1; mem_rdata = vecs[i].rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        chk($sformatf("v%0d_valid", i), d_valid, 1);
        chk($sformatf("v%0d_errflag", i), d_err, 0);
        chk($sformatf("v%0d_rdata", i), d_rdata, vecs[i].exp_rdata);
        chk($sformatf("v%0d_en_off", i), mem_en, 0);
        chk($sformatf("v%0d_stall_off", i), stall_mem, 0);
        d_req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_pulse", i), d_valid, 0);
      end
    end

    // Contention with zero-wait memory: expect D,D,D,D,I,D,D,D,D,I
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h500;
    if_req = 1'b1; if_addr = 32'h80; mem_ready = 1'b1; mem_rdata = 32'h0;
    g = 0; got = 10'b0;
    for (int c = 0; c < 40 && g < 10; c++) begin
      @(negedge clk);
      if (mem_en) begin
        got[g] = (mem_addr == 32'h80);
        g++;
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("grant_count", g, 10);
    chk("grant_seq", got, 10'b10000_10000);
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);

    // Data timeout: ready never arrives
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h300;
    n = 0; found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (d_valid) begin found = 1'b1; break; end
      if (mem_en) n++;
    end
    chk("dto_found", found, 1); chk("dto_cycles", n, 16);
    chk("dto_err", d_err, 1); chk("dto_rdata", d_rdata, 32'h0); chk("dto_en_off", mem_en, 0);
    d_req = 1'b0;
    @(negedge clk);

    // Ready on the limit cycle counts as success
    d_req = 1'b1; d_addr = 32'h304;
    n = 0; found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (d_valid) begin found = 1'b1; break; end
      if (mem_en) n++;
      if (n == 16) begin mem_ready = 1'b1; mem_rdata = 32'h5555AAAA; end
    end
    mem_ready = 1'b0;
    chk("dlim_found", found, 1); chk("dlim_cycles", n, 16);
    chk("dlim_err", d_err, 0); chk("dlim_rdata", d_rdata, 32'h5555AAAA);
    d_req = 1'b0;
    @(negedge clk);

    // Fetch timeout delivers a NOP
    if_req = 1'b1; if_addr = 32'h70;
    n = 0; found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if_valid) begin found = 1'b1; break; end
      if (mem_en) n++;
    end
    chk("ito_found", found, 1); chk("ito_cycles", n, 16); chk("ito_rdata", if_rdata, 32'h0);
    if_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of a data access
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h400;
    @(negedge clk);
    chk("rst_pre_en", mem_en, 1);
    rst_n = 1'b0; d_req = 1'b0;
    #1;
    chk("rst_async_en", mem_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_idle_outs", 32'(outs_nonzero()), 32'h0);
    if_req = 1'b1; if_addr = 32'h84;
    @(negedge clk);
    chk("rst_recover_en", mem_en, 1); chk("rst_recover_addr", mem_addr, 32'h84);
    if_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
